// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : booth_pkg
// Purpose  : Shared definitions for the radix-4 Booth multiplier: Booth digit
//            encodings, digit-count helper and 3:2 reduction-tree sizing
//            helpers used to build the Wallace tree at elaboration time.
// Revision : 1.0 - initial release
// ============================================================================
package booth_pkg;

  // Booth digit encodings (selected multiple of the multiplicand).
  localparam logic [2:0] ZERO = 3'd0;
  localparam logic [2:0] POS1 = 3'd1;
  localparam logic [2:0] POS2 = 3'd2;
  localparam logic [2:0] NEG2 = 3'd3;
  localparam logic [2:0] NEG1 = 3'd4;

  // Number of Booth digits for an operand of the given width. The operand is
  // extended by two bits first so that unsigned all-ones values and the most
  // negative signed value still recode exactly.
  function automatic int npp(input int width);
    return width / 2 + 1;
  endfunction

  // Map a 3-bit multiplier window {b[2j+1], b[2j], b[2j-1]} to a digit code.
  function automatic logic [2:0] booth_encode(input logic [2:0] trip);
    logic [2:0] d;
    case (trip)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

  // Number of rows still present after `lvl` levels of 3:2 compression.
  // Each level turns every full group of three rows into two and passes the
  // leftover rows straight through.
  function automatic int csa_rows(input int n, input int lvl);
    int r;
    r = n;
    for (int i = 0; i < lvl; i++) begin
      r = 2 * (r / 3) + (r % 3);
    end
    return r;
  endfunction

  // Ceil-depth of a 3:2 tree: levels needed to reduce n rows down to two.
  function automatic int csa_depth(input int n);
    int r;
    int d;
    r = n;
    d = 0;
    while (r > 2) begin
      r = 2 * (r / 3) + (r % 3);
      d++;
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_csa_tree.sv
`default_nettype none
// ============================================================================
// Module   : booth_csa_tree
// Purpose  : Purely combinational Wallace reduction of NPP partial products
//            (each 2*WIDTH bits) down to one sum and one carry vector.
// Ports    : i_pp    - NPP partial products, row k at [k*2*WIDTH +: 2*WIDTH]
//            o_sum   - final sum vector
//            o_carry - final carry vector (already weighted)
// Revision : 1.0 - initial release
// ============================================================================
module booth_csa_tree
  import booth_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NPP   = 17
) (
  input  logic [NPP*2*WIDTH-1:0] i_pp,
  output logic [2*WIDTH-1:0]     o_sum,
  output logic [2*WIDTH-1:0]     o_carry
);

  localparam int c_W2    = 2 * WIDTH;
  localparam int c_DEPTH = csa_depth(NPP);

  // Each level owns its own input/output bundles; the row count of every
  // level is known at elaboration time from csa_rows().
  for (genvar l = 0; l < c_DEPTH; l++) begin : g_lvl
    localparam int c_NIN  = csa_rows(NPP, l);
    localparam int c_NGRP = c_NIN / 3;
    localparam int c_NREM = c_NIN % 3;
    localparam int c_NOUT = 2 * c_NGRP + c_NREM;

    logic [c_NIN*c_W2-1:0]  w_in;
    logic [c_NOUT*c_W2-1:0] w_out;

    if (l == 0) begin : g_first
      assign w_in = i_pp;
    end else begin : g_next
      assign w_in = g_lvl[l-1].w_out;
    end

    for (genvar g = 0; g < c_NGRP; g++) begin : g_csa
      csa_3_2 #(
        .WIDTH (c_W2)
      ) u_csa (
        .i_x     (w_in[(3*g+0)*c_W2 +: c_W2]),
        .i_y     (w_in[(3*g+1)*c_W2 +: c_W2]),
        .i_z     (w_in[(3*g+2)*c_W2 +: c_W2]),
        .o_sum   (w_out[(2*g+0)*c_W2 +: c_W2]),
        .o_carry (w_out[(2*g+1)*c_W2 +: c_W2])
      );
    end

    // Rows that do not fill a group of three ride through to the next level.
    if (c_NREM > 0) begin : g_pass
      assign w_out[2*c_NGRP*c_W2 +: c_NREM*c_W2] =
             w_in[3*c_NGRP*c_W2 +: c_NREM*c_W2];
    end
  end

  assign o_sum   = g_lvl[c_DEPTH-1].w_out[0    +: c_W2];
  assign o_carry = g_lvl[c_DEPTH-1].w_out[c_W2 +: c_W2];

endmodule
`default_nettype wire

// File: rtl/csa_3_2.sv
`default_nettype none
// ============================================================================
// Module   : csa_3_2
// Purpose  : Vector 3:2 carry-save adder cell. x + y + z == sum + carry
//            (modulo 2^WIDTH); the carry vector is already shifted left.
// Ports    : i_x, i_y, i_z - addend vectors
//            o_sum         - bitwise sum
//            o_carry       - majority carries, weighted one bit up
// Revision : 1.0 - initial release
// ============================================================================
module csa_3_2 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic [WIDTH-1:0] i_z,
  output logic [WIDTH-1:0] o_sum,
  output logic [WIDTH-1:0] o_carry
);

  assign o_sum = i_x ^ i_y ^ i_z;

  // The carry out of the top bit falls outside the modulo range, so only the
  // lower WIDTH-1 majority bits are formed.
  assign o_carry[WIDTH-1:1] = (i_x[WIDTH-2:0] & i_y[WIDTH-2:0]) |
                              (i_x[WIDTH-2:0] & i_z[WIDTH-2:0]) |
                              (i_y[WIDTH-2:0] & i_z[WIDTH-2:0]);
  assign o_carry[0] = 1'b0;

endmodule
`default_nettype wire

// File: rtl/booth_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : booth_mul_pipe
// Purpose  : Three-stage pipelined radix-4 Booth multiplier with per-operand
//            signedness, valid/ready handshake and a passthrough tag.
//              S1: register extended operands and tag
//              S2: Booth partial products + 3:2 tree -> sum/carry registers
//              S3: carry-propagate add -> out_product/out_tag
// Ports    : clk, rst_n             - clock, async active-low reset
//            in_valid/in_ready      - input handshake
//            in_a, in_b             - multiplicand, multiplier
//            in_a_signed/in_b_signed- per-operand two's complement flags
//            in_tag                 - opaque tag returned with the result
//            out_valid/out_ready    - output handshake
//            out_product, out_tag   - full 2*WIDTH product and its tag
//            busy                   - any pipeline stage holds a valid op
// Revision : 1.0 - initial release
// ============================================================================
module booth_mul_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_a_signed,
  input  logic                 in_b_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  import booth_pkg::*;

  localparam int c_XW  = WIDTH + 2;
  localparam int c_W2  = 2 * WIDTH;
  localparam int c_NPP = npp(WIDTH);
  localparam logic [c_W2-1:0] c_ONE = {{(c_W2-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------
  // Handshake: the whole pipe moves as one unit whenever the output slot
  // is free or being drained.
  // ---------------------------------------------------------------------
  logic w_advance;
  logic w_accept;

  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;
  assign w_accept  = in_valid && w_advance;

  // ---------------------------------------------------------------------
  // Operand extension to WIDTH+2 bits. The signedness flags are fully
  // absorbed into the extension bits, so they need no register of their own.
  // ---------------------------------------------------------------------
  logic          w_a_sx;
  logic          w_b_sx;
  logic [c_XW-1:0] w_a_ext;
  logic [c_XW-1:0] w_b_ext;

  assign w_a_sx  = in_a_signed & in_a[WIDTH-1];
  assign w_b_sx  = in_b_signed & in_b[WIDTH-1];
  assign w_a_ext = {w_a_sx, w_a_sx, in_a};
  assign w_b_ext = {w_b_sx, w_b_sx, in_b};

  // ---------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------
  logic              r_s1_valid;
  logic [c_XW-1:0]   r_s1_a;
  logic [c_XW-1:0]   r_s1_b;
  logic [TAG_W-1:0]  r_s1_tag;

  logic              r_s2_valid;
  logic [c_W2-1:0]   r_s2_sum;
  logic [c_W2-1:0]   r_s2_carry;
  logic [TAG_W-1:0]  r_s2_tag;

  // ---------------------------------------------------------------------
  // S2 combinational: Booth recoding and partial products
  // ---------------------------------------------------------------------
  logic [c_W2-1:0]       w_a;
  logic [c_W2-1:0]       w_a2;
  logic [c_W2-1:0]       w_na;
  logic [c_W2-1:0]       w_na2;
  logic [c_XW:0]         w_bx;
  logic [c_NPP*c_W2-1:0] w_pp;
  logic [c_W2-1:0]       w_sum;
  logic [c_W2-1:0]       w_carry;

  // Multiplicand sign-extended across the full product width; the extended
  // top bit already carries the chosen signedness.
  assign w_a   = {{(c_W2-c_XW){r_s1_a[c_XW-1]}}, r_s1_a};
  assign w_a2  = {w_a[c_W2-2:0], 1'b0};
  assign w_na  = ~w_a  + c_ONE;
  assign w_na2 = ~w_a2 + c_ONE;

  // Multiplier with the implicit bit -1 = 0 appended at the bottom, so
  // digit j reads w_bx[2j+2:2j].
  assign w_bx = {r_s1_b, 1'b0};

  for (genvar j = 0; j < c_NPP; j++) begin : g_pp
    logic [2:0]      w_dig;
    logic [c_W2-1:0] w_term;

    assign w_dig = booth_encode(w_bx[2*j+2 -: 3]);

    always_comb begin
      case (w_dig)
        POS1:    w_term = w_a;
        POS2:    w_term = w_a2;
        NEG1:    w_term = w_na;
        NEG2:    w_term = w_na2;
        default: w_term = '0;
      endcase
    end

    // Weight 4^j; bits shifted past the product width are discarded.
    assign w_pp[j*c_W2 +: c_W2] = w_term << (2 * j);
  end

  booth_csa_tree #(
    .WIDTH (WIDTH),
    .NPP   (c_NPP)
  ) u_tree (
    .i_pp    (w_pp),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  // ---------------------------------------------------------------------
  // Stage registers. Bubbles are kept in place rather than collapsed, so a
  // stall freezes every stage together.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_tag    <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_sum    <= '0;
      r_s2_carry  <= '0;
      r_s2_tag    <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
      out_tag     <= '0;
    end else if (w_advance) begin
      r_s1_valid  <= w_accept;
      r_s1_a      <= w_a_ext;
      r_s1_b      <= w_b_ext;
      r_s1_tag    <= in_tag;
      r_s2_valid  <= r_s1_valid;
      r_s2_sum    <= w_sum;
      r_s2_carry  <= w_carry;
      r_s2_tag    <= r_s1_tag;
      out_valid   <= r_s2_valid;
      out_product <= r_s2_sum + r_s2_carry;
      out_tag     <= r_s2_tag;
    end
  end

  assign busy = r_s1_valid | r_s2_valid | out_valid;

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_mul_pipe
// Purpose  : Self-checking bench for booth_mul_pipe. A WIDTH=32 instance is
//            exercised with directed boundary vectors, streaming, stall and
//            mid-flight reset scenarios; a WIDTH=8 instance runs a grid of
//            edge operands in all four signedness modes against a
//            behavioural product model with random output backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_mul_pipe;

  logic        clk;
  logic        rst_n;

  // WIDTH = 32 instance
  logic        in_valid, in_ready, in_a_signed, in_b_signed;
  logic [31:0] in_a, in_b;
  logic [3:0]  in_tag, out_tag;
  logic        out_valid, out_ready, busy;
  logic [63:0] out_product;

  // WIDTH = 8 instance
  logic        in_valid8, in_ready8, in_a_signed8, in_b_signed8;
  logic [7:0]  in_a8, in_b8;
  logic [3:0]  in_tag8, out_tag8;
  logic        out_valid8, out_ready8, busy8;
  logic [15:0] out_product8;

  int n_checks;
  int n_fail;

  booth_mul_pipe #(.WIDTH(32), .TAG_W(4)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_a_signed (in_a_signed),
    .in_b_signed (in_b_signed),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_tag     (out_tag),
    .busy        (busy)
  );

  booth_mul_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid8),
    .in_ready    (in_ready8),
    .in_a        (in_a8),
    .in_b        (in_b8),
    .in_a_signed (in_a_signed8),
    .in_b_signed (in_b_signed8),
    .in_tag      (in_tag8),
    .out_valid   (out_valid8),
    .out_ready   (out_ready8),
    .out_product (out_product8),
    .out_tag     (out_tag8),
    .busy        (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------
  task automatic test_reset();
    #12;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (out_product !== 64'h0) begin n_fail++; $display("FAIL reset_product: got %h want 0", out_product); end
    n_checks++; if (out_tag !== 4'h0) begin n_fail++; $display("FAIL reset_tag: got %h want 0", out_tag); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid8 !== 1'b0 || busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_w8: got valid %b busy %b want 0 0", out_valid8, busy8); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One isolated operation; checks latency, product and tag.
  task automatic test_product(input logic [31:0] a, input logic [31:0] b,
                              input logic as, input logic bs,
                              input logic [3:0] tag, input logic [63:0] exp,
                              input string name);
    int n;
    @(negedge clk);
    in_a = a; in_b = b; in_a_signed = as; in_b_signed = bs; in_tag = tag;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    n_checks++; if (!out_valid || n != 3) begin n_fail++; $display("FAIL %s_latency: got %0d cycles (valid %b) want 3", name, n, out_valid); end
    n_checks++; if (out_product !== exp) begin n_fail++; $display("FAIL %s_product: got %h want %h", name, out_product, exp); end
    n_checks++; if (out_tag !== tag) begin n_fail++; $display("FAIL %s_tag: got %h want %h", name, out_tag, tag); end
    @(negedge clk);
  endtask

  task automatic test_boundary();
    test_product(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 4'd5, 64'h4000_0000_0000_0000, "minneg_ss");
    test_product(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'd6, 64'hFFFF_FFFE_0000_0001, "allones_uu");
    test_product(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'd7, 64'hFFFF_FFFF_0000_0001, "allones_su");
    test_product(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'd8, 64'hFFFF_FFFF_0000_0001, "allones_us");
    test_product(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'd9, 64'h0000_0000_0000_0001, "allones_ss");
    test_product(32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 1'b1, 4'hA, 64'hFFFF_FFFF_FFFF_FFEB, "small_neg_ss");
    test_product(32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 4'hB, 64'h0, "times_zero");
  endtask

  // Four ops issued on consecutive cycles with no stall: one result per cycle.
  task automatic test_back_to_back();
    logic [63:0] exp [4];
    int issued, got, cyc;
    exp[0] = 64'h0000_0000_FFFF_FFFF;
    exp[1] = 64'h0000_0001_FFFF_FFFE;
    exp[2] = 64'h0000_0002_FFFF_FFFD;
    exp[3] = 64'h0000_0003_FFFF_FFFC;
    issued = 0; got = 0; cyc = 0;
    while (got < 4 && cyc < 40) begin
      @(negedge clk);
      in_valid = (issued < 4);
      in_a = 32'(issued + 1); in_b = 32'hFFFF_FFFF;
      in_a_signed = 1'b0; in_b_signed = 1'b0; in_tag = 4'(8 + issued);
      out_ready = 1'b1;
      #1;
      if (out_valid && out_ready) begin
        n_checks++; if (cyc != 3 + got) begin n_fail++; $display("FAIL b2b_timing[%0d]: got cycle %0d want %0d", got, cyc, 3 + got); end
        n_checks++; if (out_product !== exp[got]) begin n_fail++; $display("FAIL b2b_product[%0d]: got %h want %h", got, out_product, exp[got]); end
        n_checks++; if (out_tag !== 4'(8 + got)) begin n_fail++; $display("FAIL b2b_tag[%0d]: got %h want %h", got, out_tag, 4'(8 + got)); end
        got++;
      end
      if (in_valid && in_ready) issued++;
      cyc++;
    end
    n_checks++; if (got != 4) begin n_fail++; $display("FAIL b2b_count: got %0d results want 4", got); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Four ops with out_ready low for cycles 2..6; pipe fills and freezes.
  task automatic test_backpressure();
    logic [63:0] exp [4];
    int issued, got, cyc;
    exp[0] = 64'hFFFF_FFFF_FFFF_FFE0;
    exp[1] = 64'hFFFF_FFFF_FFFF_FFDE;
    exp[2] = 64'hFFFF_FFFF_FFFF_FFDC;
    exp[3] = 64'hFFFF_FFFF_FFFF_FFDA;
    issued = 0; got = 0; cyc = 0;
    while (got < 4 && cyc < 60) begin
      @(negedge clk);
      in_valid = (issued < 4);
      in_a = 32'(16 + issued); in_b = 32'hFFFF_FFFE;
      in_a_signed = 1'b1; in_b_signed = 1'b1; in_tag = 4'(issued);
      out_ready = !(cyc >= 2 && cyc <= 6);
      #1;
      if (cyc >= 3 && cyc <= 6) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[c%0d]: got %b want 0", cyc, in_ready); end
        n_checks++; if (out_product !== exp[0]) begin n_fail++; $display("FAIL bp_hold_product[c%0d]: got %h want %h", cyc, out_product, exp[0]); end
        n_checks++; if (out_tag !== 4'd0) begin n_fail++; $display("FAIL bp_hold_tag[c%0d]: got %h want 0", cyc, out_tag); end
      end
      if (out_valid && out_ready) begin
        n_checks++; if (out_product !== exp[got]) begin n_fail++; $display("FAIL bp_product[%0d]: got %h want %h", got, out_product, exp[got]); end
        n_checks++; if (out_tag !== 4'(got)) begin n_fail++; $display("FAIL bp_tag[%0d]: got %h want %h", got, out_tag, 4'(got)); end
        got++;
      end
      if (in_valid && in_ready) issued++;
      cyc++;
    end
    n_checks++; if (got != 4) begin n_fail++; $display("FAIL bp_count: got %0d results want 4", got); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got valid %b busy %b want 0 0", out_valid, busy); end
  endtask

  // Two ops in flight, then an asynchronous reset before either emerges.
  task automatic test_reset_midflight();
    int extra;
    @(negedge clk);
    in_a = 32'h0000_0003; in_b = 32'h0000_0005; in_a_signed = 1'b0; in_b_signed = 1'b0;
    in_tag = 4'hC; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_tag = 4'hD;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before: got %b want 1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    n_checks++; if (out_product !== 64'h0) begin n_fail++; $display("FAIL rst_mid_product: got %h want 0", out_product); end
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL rst_mid_ghost: got %0d results want 0", extra); end
  endtask

  // WIDTH=8 grid of edge operands in all modes, random output backpressure.
  task automatic test_w8_modes();
    logic [7:0]  vals [10];
    logic [19:0] q [$];
    logic [19:0] ent;
    logic [7:0]  a, b;
    logic        as, bs;
    logic signed [9:0]  ea, eb;
    logic signed [19:0] p;
    int idx, got, cyc, total, bad;
    vals[0] = 8'h00; vals[1] = 8'h01; vals[2] = 8'h02; vals[3] = 8'h7F; vals[4] = 8'h80;
    vals[5] = 8'h81; vals[6] = 8'hFE; vals[7] = 8'hFF; vals[8] = 8'h55; vals[9] = 8'hAA;
    total = 400; idx = 0; got = 0; cyc = 0; bad = 0;
    while (got < total && cyc < 5000) begin
      @(negedge clk);
      a  = vals[(idx / 10) % 10];
      b  = vals[idx % 10];
      as = ((idx / 100) & 1) != 0;
      bs = ((idx / 200) & 1) != 0;
      in_valid8 = (idx < total);
      in_a8 = a; in_b8 = b; in_a_signed8 = as; in_b_signed8 = bs; in_tag8 = 4'(idx);
      out_ready8 = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid8 && out_ready8) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL w8_unexpected: got product %h tag %h with empty scoreboard", out_product8, out_tag8);
        end else begin
          ent = q.pop_front();
          n_checks++;
          if (out_product8 !== ent[15:0] || out_tag8 !== ent[19:16]) begin
            n_fail++;
            if (bad < 10) $display("FAIL w8_result[%0d]: got %h/tag %h want %h/tag %h", got, out_product8, out_tag8, ent[15:0], ent[19:16]);
            bad++;
          end
        end
        got++;
      end
      if (in_valid8 && in_ready8) begin
        ea = {as & a[7], as & a[7], a};
        eb = {bs & b[7], bs & b[7], b};
        p  = ea * eb;
        q.push_back({4'(idx), p[15:0]});
        idx++;
      end
      cyc++;
    end
    n_checks++; if (got != total) begin n_fail++; $display("FAIL w8_count: got %0d results want %0d", got, total); end
    @(negedge clk);
    in_valid8 = 1'b0; out_ready8 = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_a_signed = 1'b0; in_b_signed = 1'b0;
    in_tag = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; in_a8 = '0; in_b8 = '0; in_a_signed8 = 1'b0; in_b_signed8 = 1'b0;
    in_tag8 = '0; out_ready8 = 1'b1;

    test_reset();
    test_boundary();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_w8_modes();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
